// File: rtl/timer_apb_pkg.sv
// Shared definitions for the timer APB initiator, the timer register file and the bench.
package timer_apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [11:0] TCR   = 12'h000;
   localparam logic [11:0] TDR0  = 12'h004;
   localparam logic [11:0] TDR1  = 12'h008;
   localparam logic [11:0] TCMP0 = 12'h00C;
   localparam logic [11:0] TCMP1 = 12'h010;
   localparam logic [11:0] TIER  = 12'h014;
   localparam logic [11:0] TISR  = 12'h018;
   localparam logic [11:0] THCSR = 12'h01C;

   // Only word-aligned byte addresses reach the bus.
   function automatic logic addr_misaligned(input logic [1:0] lo);
      return lo != 2'b00;
   endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating wait-state counter; flags the cycle on which the count reaches the limit.
module apb_timeout_cnt #(
   parameter int unsigned CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             expired_c
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] sat;

   // A zero limit disables expiry; the count then saturates at all-ones.
   assign sat = (limit == '0) ? '1 : limit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable && (cnt != sat)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expired_c = enable && (limit != '0) && (cnt == limit - CNT_W'(1));

endmodule

// File: rtl/timer_apb_master.sv
// APB initiator: single-beat host commands to APB transfers on the timer register file,
// with wait-state timeout abort and misaligned-address rejection.
module timer_apb_master
   import timer_apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 12,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [3:0]            cmd_strb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   output logic [3:0]            pstrb,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   state_t state, state_nxt;
   logic   misalign_c;
   logic   cnt_clear, cnt_en, expired_c;

   logic                  cmd_ready_d, rsp_valid_d, rsp_err_d, rsp_timeout_d;
   logic                  psel_d, penable_d, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_d, rsp_rdata_d;
   logic [3:0]            pstrb_d;

   assign misalign_c = addr_misaligned(cmd_addr[1:0]);
   assign cnt_en     = (state == ACCESS) && !pready;
   assign cnt_clear  = (state == RESP) && rsp_ready;

   apb_timeout_cnt #(.CNT_W(CNT_W)) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .clear     (cnt_clear),
      .enable    (cnt_en),
      .limit     (CNT_W'(TIMEOUT_CYCLES)),
      .expired_c (expired_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (cmd_valid) state_nxt = misalign_c ? RESP : SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (pready || expired_c) state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of every registered output; pready on the limit cycle completes normally.
   always_comb begin
      cmd_ready_d   = (state_nxt == IDLE);
      rsp_valid_d   = rsp_valid;
      rsp_err_d     = rsp_err;
      rsp_timeout_d = rsp_timeout;
      rsp_rdata_d   = rsp_rdata;
      psel_d        = psel;
      penable_d     = penable;
      pwrite_d      = pwrite;
      paddr_d       = paddr;
      pwdata_d      = pwdata;
      pstrb_d       = pstrb;
      unique case (state)
         IDLE: begin
            if (cmd_valid) begin
               paddr_d  = cmd_addr;
               pwrite_d = cmd_write;
               pwdata_d = cmd_wdata;
               pstrb_d  = cmd_write ? cmd_strb : 4'b0000;
               if (misalign_c) begin
                  rsp_valid_d   = 1'b1;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b0;
                  rsp_rdata_d   = '0;
               end else begin
                  psel_d = 1'b1;
               end
            end
         end
         SETUP: penable_d = 1'b1;
         ACCESS: begin
            if (pready) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = pslverr;
               rsp_timeout_d = 1'b0;
               rsp_rdata_d   = (!pwrite && !pslverr) ? prdata : '0;
            end else if (expired_c) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_rdata_d   = '0;
            end
         end
         RESP: if (rsp_ready) rsp_valid_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_rdata   <= '0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         pstrb       <= 4'b0000;
      end else begin
         cmd_ready   <= cmd_ready_d;
         rsp_valid   <= rsp_valid_d;
         rsp_err     <= rsp_err_d;
         rsp_timeout <= rsp_timeout_d;
         rsp_rdata   <= rsp_rdata_d;
         psel        <= psel_d;
         penable     <= penable_d;
         pwrite      <= pwrite_d;
         paddr       <= paddr_d;
         pwdata      <= pwdata_d;
         pstrb       <= pstrb_d;
      end
   end

endmodule

// File: tb/tb_timer_apb_master.sv
// Bench for timer_apb_master: directed scenarios then random traffic against a transaction-level model.
module tb_timer_apb_master;
   import timer_apb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [11:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite;
   logic [11:0] paddr;
   logic [31:0] pwdata, prdata;
   logic [3:0]  pstrb;
   logic        pready, pslverr;

   int tests = 0;
   int fails = 0;

   // Slave behaviour knobs, set by the stimulus.
   int unsigned slv_waits = 0;
   logic        slv_err   = 1'b0;
   logic        slv_hang  = 1'b0;
   int unsigned acc_cnt;
   logic        noise;
   logic        apb_rdy;
   logic [31:0] slv_mem [16];
   logic [31:0] ref_mem [16];

   timer_apb_master #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   // Register-file slave; pready/pslverr carry random noise outside ACCESS.
   assign apb_rdy = psel && penable && !slv_hang && (acc_cnt == slv_waits);
   assign pready  = (psel && penable) ? apb_rdy : noise;
   assign pslverr = (psel && penable) ? (apb_rdy && slv_err) : noise;
   assign prdata  = slv_err ? 32'hDEAD_BEEF : slv_mem[paddr[5:2]];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_cnt <= 0;
         noise   <= 1'b0;
         for (int i = 0; i < 16; i++) slv_mem[i] <= 32'h0;
      end else begin
         noise <= 1'($urandom_range(0, 1));
         if (psel && penable && !apb_rdy) acc_cnt <= acc_cnt + 1;
         else                             acc_cnt <= 0;
         if (apb_rdy && pwrite && !slv_err)
            for (int b = 0; b < 4; b++)
               if (pstrb[b]) slv_mem[paddr[5:2]][8*b +: 8] <= pwdata[8*b +: 8];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One host transaction, checked against the transfer rules.
   task automatic do_cmd(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input int unsigned waits, input logic err,
                         input logic hang, input int hold);
      logic        misal;
      logic [3:0]  idx;
      logic [31:0] exp_rdata, snap_rdata;
      logic        snap_err, snap_to;
      int          cyc, n_setup, n_access, bad_stable, bad_hold, exp_lat;
      misal = (addr[1:0] != 2'b00);
      idx   = addr[5:2];
      exp_rdata = (!wr && !misal && !err && !hang) ? ref_mem[idx] : 32'h0;
      exp_lat   = misal ? 1 : (hang ? 18 : 3 + int'(waits));
      slv_waits = waits;
      slv_err   = err;
      slv_hang  = hang;
      check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
      rsp_ready = 1'b0;
      tick();
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = 12'($urandom);
      cmd_wdata = $urandom;
      cyc = 1; n_setup = 0; n_access = 0; bad_stable = 0;
      while (!rsp_valid && cyc < 40) begin
         if (psel && !penable) n_setup++;
         if (psel && penable)  n_access++;
         if (psel && (paddr !== addr || pwrite !== wr || pwdata !== wd ||
                      pstrb !== (wr ? st : 4'b0000))) bad_stable++;
         if (cmd_ready) bad_stable++;
         tick();
         cyc++;
      end
      check("latency", 32'(cyc), 32'(exp_lat));
      check("setup_cycles", 32'(n_setup), misal ? 32'd0 : 32'd1);
      check("access_cycles", 32'(n_access), misal ? 32'd0 : (hang ? 32'd16 : 32'(waits + 1)));
      check("apb_stable", 32'(bad_stable), 32'd0);
      check("psel_at_rsp", 32'({psel, penable}), 32'd0);
      check("rsp_err", 32'(rsp_err), 32'(misal || err || hang));
      check("rsp_timeout", 32'(rsp_timeout), 32'(hang && !misal));
      check("rsp_rdata", rsp_rdata, exp_rdata);
      snap_rdata = rsp_rdata; snap_err = rsp_err; snap_to = rsp_timeout;
      bad_hold = 0;
      for (int h = 0; h < hold; h++) begin
         tick();
         if (!rsp_valid || cmd_ready || psel || rsp_rdata !== snap_rdata ||
             rsp_err !== snap_err || rsp_timeout !== snap_to) bad_hold++;
      end
      if (hold > 0) check("rsp_hold", 32'(bad_hold), 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_done", 32'({rsp_valid, cmd_ready}), 32'b01);
      if (wr && !misal && !err && !hang)
         for (int b = 0; b < 4; b++)
            if (st[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
   endtask

   initial begin
      logic [11:0] ra;
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
      tick(); tick();
      rst = 1'b0;
      tick();

      check("reset_ctl", 32'({cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite}),
            32'b1000000);
      check("reset_paddr", 32'(paddr), 32'h0);
      check("reset_pwdata", pwdata, 32'h0);
      check("reset_pstrb_rdata", rsp_rdata | 32'(pstrb), 32'h0);

      do_cmd(1'b1, TCMP0, 32'h0000_0010, 4'hF, 0, 1'b0, 1'b0, 0);
      check("slave_tcmp0", slv_mem[3], 32'h0000_0010);
      do_cmd(1'b1, TCR, 32'h0000_0100, 4'hF, 1, 1'b0, 1'b0, 0);
      do_cmd(1'b0, TCR, 32'h0, 4'hF, 3, 1'b0, 1'b0, 1);
      do_cmd(1'b0, 12'h020, 32'h0, 4'h0, 0, 1'b1, 1'b0, 0);
      do_cmd(1'b0, TDR0, 32'h0, 4'h0, 0, 1'b0, 1'b1, 2);
      do_cmd(1'b1, 12'h006, 32'h1234_5678, 4'hF, 0, 1'b0, 1'b0, 5);

      // Reset asserted during ACCESS of a TISR write.
      slv_hang = 1'b1; slv_err = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = TISR; cmd_wdata = 32'hFFFF_FFFF; cmd_strb = 4'hF;
      tick();
      cmd_valid = 1'b0;
      tick();
      check("pre_rst_access", 32'({psel, penable}), 32'b11);
      #2 rst = 1'b1;
      #1;
      check("async_rst", 32'({psel, penable, rsp_valid, cmd_ready}), 32'b0001);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
      tick(); tick();
      check("post_rst", 32'({cmd_ready, rsp_valid, psel}), 32'b100);

      // Random traffic.
      for (int t = 0; t < 60; t++) begin
         ra = 12'($urandom_range(0, 15) * 4);
         if ($urandom_range(0, 7) == 0) ra = ra | 12'($urandom_range(1, 3));
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
         do_cmd(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 4), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 15) == 0), int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
